// File: rtl/csr_file_ext.sv
`default_nettype none
// ============================================================================
// Module      : csr_file_ext
// Description : Machine-mode CSR file with trap/mret handling, local
//               interrupt pending/enable logic and optional 64-bit
//               mcycle/minstret counters.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file_ext #(
  parameter int          IRQ_NUM     = 16,
  parameter int          COUNTERS_EN = 1,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         opcode_i,
  input  logic [11:0]        addr_i,
  input  logic               write_enable_i,
  input  logic [31:0]        rs1_data_i,
  input  logic [31:0]        imm_data_i,
  input  logic [31:0]        pc_i,
  input  logic               trap_i,
  input  logic [31:0]        mcause_i,
  input  logic               mret_i,
  input  logic               instr_retired_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  output logic [31:0]        read_data_o,
  output logic [31:0]        mie_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        mtvec_o,
  output logic               irq_pending_o,
  output logic [31:0]        irq_cause_o,
  output logic               illegal_csr_o
);

  // CSR addresses
  localparam logic [11:0] c_addr_mstatus   = 12'h300;
  localparam logic [11:0] c_addr_mie       = 12'h304;
  localparam logic [11:0] c_addr_mtvec     = 12'h305;
  localparam logic [11:0] c_addr_mscratch  = 12'h340;
  localparam logic [11:0] c_addr_mepc      = 12'h341;
  localparam logic [11:0] c_addr_mcause    = 12'h342;
  localparam logic [11:0] c_addr_mip       = 12'h344;
  localparam logic [11:0] c_addr_mcycle    = 12'hB00;
  localparam logic [11:0] c_addr_minstret  = 12'hB02;
  localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_addr_minstreth = 12'hB82;

  // Local interrupt lines live at bits [16 +: IRQ_NUM] of mie/mip
  localparam logic [31:0] c_irq_mask  = ((32'h1 << IRQ_NUM) - 32'h1) << 16;
  // Low two bits of trap vector / exception PC are always zero
  localparam logic [31:0] c_align_msk = 32'hFFFF_FFFC;

  // Architectural state
  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [31:0]        r_mie;
  logic [31:0]        r_mtvec;
  logic [31:0]        r_mscratch;
  logic [31:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [IRQ_NUM-1:0] r_mip;

  // Counter views (zero when counters are not built)
  logic [63:0]        w_mcycle;
  logic [63:0]        w_minstret;

  // Decode / datapath wires
  logic [31:0]        w_mstatus;
  logic [31:0]        w_mip;
  logic [31:0]        w_rdata;
  logic               w_mapped;
  logic               w_writable;
  logic [31:0]        w_operand;
  logic [31:0]        w_wdata;
  logic               w_op_valid;
  logic               w_do_write;
  logic               w_wr_mstatus;
  logic               w_wr_mie;
  logic               w_wr_mtvec;
  logic               w_wr_mscratch;
  logic               w_wr_mepc;
  logic               w_wr_mcause;
  logic               w_wr_mcycle;
  logic               w_wr_mcycleh;
  logic               w_wr_minstret;
  logic               w_wr_minstreth;
  logic [IRQ_NUM-1:0] w_pend_en;
  logic [31:0]        w_irq_cause;

  // MPP is hardwired to machine mode (2'b11); only MIE and MPIE are stored
  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mip     = 32'(r_mip) << 16;

  // Address decode and pre-update read mux
  always_comb begin
    w_mapped   = 1'b1;
    w_writable = 1'b1;
    w_rdata    = 32'd0;
    case (addr_i)
      c_addr_mstatus:  w_rdata = w_mstatus;
      c_addr_mie:      w_rdata = r_mie;
      c_addr_mtvec:    w_rdata = r_mtvec;
      c_addr_mscratch: w_rdata = r_mscratch;
      c_addr_mepc:     w_rdata = r_mepc;
      c_addr_mcause:   w_rdata = r_mcause;
      c_addr_mip: begin
        w_rdata    = w_mip;
        w_writable = 1'b0;
      end
      c_addr_mcycle: begin
        w_rdata  = w_mcycle[31:0];
        w_mapped = (COUNTERS_EN != 0);
      end
      c_addr_mcycleh: begin
        w_rdata  = w_mcycle[63:32];
        w_mapped = (COUNTERS_EN != 0);
      end
      c_addr_minstret: begin
        w_rdata  = w_minstret[31:0];
        w_mapped = (COUNTERS_EN != 0);
      end
      c_addr_minstreth: begin
        w_rdata  = w_minstret[63:32];
        w_mapped = (COUNTERS_EN != 0);
      end
      default: begin
        w_mapped   = 1'b0;
        w_writable = 1'b0;
      end
    endcase
    if (!w_mapped) begin
      w_rdata    = 32'd0;
      w_writable = 1'b0;
    end
  end

  // Write-data generation: RW / RS / RC with register or immediate operand
  always_comb begin
    w_operand  = opcode_i[2] ? imm_data_i : rs1_data_i;
    w_op_valid = 1'b1;
    w_wdata    = w_rdata;
    case (opcode_i[1:0])
      2'b01:   w_wdata = w_operand;
      2'b10:   w_wdata = w_rdata | w_operand;
      2'b11:   w_wdata = w_rdata & ~w_operand;
      default: w_op_valid = 1'b0;
    endcase
  end

  // A trap in the same cycle always squashes the CSR write
  assign w_do_write     = write_enable_i & w_mapped & w_writable & w_op_valid & ~trap_i;
  assign w_wr_mstatus   = w_do_write & (addr_i == c_addr_mstatus);
  assign w_wr_mie       = w_do_write & (addr_i == c_addr_mie);
  assign w_wr_mtvec     = w_do_write & (addr_i == c_addr_mtvec);
  assign w_wr_mscratch  = w_do_write & (addr_i == c_addr_mscratch);
  assign w_wr_mepc      = w_do_write & (addr_i == c_addr_mepc);
  assign w_wr_mcause    = w_do_write & (addr_i == c_addr_mcause);
  assign w_wr_mcycle    = w_do_write & (addr_i == c_addr_mcycle);
  assign w_wr_mcycleh   = w_do_write & (addr_i == c_addr_mcycleh);
  assign w_wr_minstret  = w_do_write & (addr_i == c_addr_minstret);
  assign w_wr_minstreth = w_do_write & (addr_i == c_addr_minstreth);

  // Core CSR state: trap capture, mret restore and software writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'd0;
      r_mtvec        <= RESET_MTVEC;
      r_mscratch     <= 32'd0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mip          <= '0;
    end else begin
      r_mip <= irq_i;
      if (trap_i) begin
        r_mepc         <= pc_i & c_align_msk;
        r_mcause       <= mcause_i;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else begin
        // mret owns the interrupt-enable stack when both target mstatus
        if (mret_i) begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
          r_mstatus_mie  <= w_wdata[3];
          r_mstatus_mpie <= w_wdata[7];
        end
        if (w_wr_mie)      r_mie      <= w_wdata & c_irq_mask;
        if (w_wr_mtvec)    r_mtvec    <= w_wdata & c_align_msk;
        if (w_wr_mscratch) r_mscratch <= w_wdata;
        if (w_wr_mepc)     r_mepc     <= w_wdata & c_align_msk;
        if (w_wr_mcause)   r_mcause   <= w_wdata;
      end
    end
  end

  generate
    if (COUNTERS_EN != 0) begin : g_counters
      logic [63:0] r_mcycle;
      logic [63:0] r_minstret;

      // mcycle: half-word load takes precedence over the free-running increment
      always_ff @(posedge clk_i) begin
        if (rst_i)             r_mcycle <= 64'd0;
        else if (w_wr_mcycle)  r_mcycle <= {r_mcycle[63:32], w_wdata};
        else if (w_wr_mcycleh) r_mcycle <= {w_wdata, r_mcycle[31:0]};
        else                   r_mcycle <= r_mcycle + 64'd1;
      end

      // minstret: half-word load takes precedence over retire counting
      always_ff @(posedge clk_i) begin
        if (rst_i)                r_minstret <= 64'd0;
        else if (w_wr_minstret)   r_minstret <= {r_minstret[63:32], w_wdata};
        else if (w_wr_minstreth)  r_minstret <= {w_wdata, r_minstret[31:0]};
        else if (instr_retired_i) r_minstret <= r_minstret + 64'd1;
      end

      assign w_mcycle   = r_mcycle;
      assign w_minstret = r_minstret;
    end else begin : g_no_counters
      assign w_mcycle   = 64'd0;
      assign w_minstret = 64'd0;
    end
  endgenerate

  assign w_pend_en = r_mip & r_mie[16 +: IRQ_NUM];

  // Lowest-numbered pending and enabled line wins
  always_comb begin
    w_irq_cause = 32'd0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (w_pend_en[i]) w_irq_cause = {1'b1, 31'(16 + i)};
    end
  end

  assign read_data_o   = w_rdata;
  assign mie_o         = r_mie;
  assign mepc_o        = r_mepc;
  assign mtvec_o       = r_mtvec;
  assign irq_pending_o = r_mstatus_mie & (|w_pend_en);
  assign irq_cause_o   = w_irq_cause;
  assign illegal_csr_o = write_enable_i & ~w_mapped;

endmodule
`default_nettype wire

// File: tb/tb_csr_file_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file_ext
// Description : Self-checking bench for csr_file_ext against a behavioural
//               model of the CSR map, traps, interrupts and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file_ext;

  localparam int          IRQ_NUM     = 4;
  localparam logic [31:0] RESET_MTVEC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [11:0] addr;
  logic        we;
  logic [31:0] rs1, imm, pc, mcause_in;
  logic        trap, mret, retired;
  logic [IRQ_NUM-1:0] irq;

  logic [31:0] rd, mie_o, mepc_o, mtvec_o, cause;
  logic        pend, illegal;
  logic [31:0] rd_nc, mie_nc, mepc_nc, mtvec_nc, cause_nc;
  logic        pend_nc, illegal_nc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_mie_g, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [IRQ_NUM-1:0] m_mip;
  logic [63:0] m_mcycle, m_minstret;

  always #5 clk = ~clk;

  csr_file_ext #(.IRQ_NUM(IRQ_NUM), .COUNTERS_EN(1), .RESET_MTVEC(RESET_MTVEC)) u_dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .addr_i(addr), .write_enable_i(we),
    .rs1_data_i(rs1), .imm_data_i(imm), .pc_i(pc), .trap_i(trap), .mcause_i(mcause_in),
    .mret_i(mret), .instr_retired_i(retired), .irq_i(irq), .read_data_o(rd),
    .mie_o(mie_o), .mepc_o(mepc_o), .mtvec_o(mtvec_o), .irq_pending_o(pend),
    .irq_cause_o(cause), .illegal_csr_o(illegal));

  csr_file_ext #(.IRQ_NUM(IRQ_NUM), .COUNTERS_EN(0), .RESET_MTVEC(RESET_MTVEC)) u_dut_nc (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .addr_i(addr), .write_enable_i(we),
    .rs1_data_i(rs1), .imm_data_i(imm), .pc_i(pc), .trap_i(trap), .mcause_i(mcause_in),
    .mret_i(mret), .instr_retired_i(retired), .irq_i(irq), .read_data_o(rd_nc),
    .mie_o(mie_nc), .mepc_o(mepc_nc), .mtvec_o(mtvec_nc), .irq_pending_o(pend_nc),
    .irq_cause_o(cause_nc), .illegal_csr_o(illegal_nc));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [11:0] a, input bit ce);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_g) << 3);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'(m_mip) << 16;
      12'hB00: return ce ? m_mcycle[31:0]    : 32'd0;
      12'hB80: return ce ? m_mcycle[63:32]   : 32'd0;
      12'hB02: return ce ? m_minstret[31:0]  : 32'd0;
      12'hB82: return ce ? m_minstret[63:32] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit mmapped(input logic [11:0] a, input bit ce);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344: return 1'b1;
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return ce;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie_g = 0; m_mpie = 0;
    m_mie = 0; m_mtvec = RESET_MTVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mip = 0; m_mcycle = 0; m_minstret = 0;
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic model_clock();
    logic [31:0] old, opd, wd;
    logic [63:0] ncyc, nins;
    bit wr, t;
    if (rst) begin
      model_reset();
      return;
    end
    old = mread(addr, 1);
    opd = opcode[2] ? imm : rs1;
    case (opcode[1:0])
      2'b01:   wd = opd;
      2'b10:   wd = old | opd;
      2'b11:   wd = old & ~opd;
      default: wd = old;
    endcase
    wr   = we && (opcode[1:0] != 2'b00) && mmapped(addr, 1) && (addr != 12'h344) && !trap;
    ncyc = m_mcycle + 64'd1;
    nins = m_minstret + (retired ? 64'd1 : 64'd0);
    if (trap) begin
      m_mepc   = {pc[31:2], 2'b00};
      m_mcause = mcause_in;
      m_mpie   = m_mie_g;
      m_mie_g  = 0;
    end else if (mret) begin
      t       = m_mpie;
      m_mpie  = 1;
      m_mie_g = t;
    end
    if (wr) begin
      case (addr)
        12'h300: begin m_mie_g = wd[3]; m_mpie = wd[7]; end
        12'h304: m_mie      = {12'd0, wd[19:16], 16'd0};
        12'h305: m_mtvec    = {wd[31:2], 2'b00};
        12'h340: m_mscratch = wd;
        12'h341: m_mepc     = {wd[31:2], 2'b00};
        12'h342: m_mcause   = wd;
        12'hB00: ncyc = {m_mcycle[63:32], wd};
        12'hB80: ncyc = {wd, m_mcycle[31:0]};
        12'hB02: nins = {m_minstret[63:32], wd};
        12'hB82: nins = {wd, m_minstret[31:0]};
        default: ;
      endcase
    end
    m_mcycle   = ncyc;
    m_minstret = nins;
    m_mip      = irq;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_cause;
    logic [IRQ_NUM-1:0] pe;
    pe = m_mip & m_mie[16 +: IRQ_NUM];
    exp_cause = 32'd0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (pe[i] && exp_cause == 32'd0) exp_cause = 32'h8000_0000 | 32'(16 + i);
    end
    chk("read_data",    rd,      mread(addr, 1));
    chk("read_data_nc", rd_nc,   mread(addr, 0));
    chk("illegal",      32'(illegal),    32'(we && !mmapped(addr, 1)));
    chk("illegal_nc",   32'(illegal_nc), 32'(we && !mmapped(addr, 0)));
    chk("irq_pending",  32'(pend), 32'(m_mie_g && (pe != 0)));
    chk("irq_cause",    cause,   exp_cause);
    chk("mie_o",        mie_o,   m_mie);
    chk("mepc_o",       mepc_o,  m_mepc);
    chk("mtvec_o",      mtvec_o, m_mtvec);
  endtask

  task automatic run_cycle();
    #2;
    check_outputs();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; opcode = 3'b000; addr = 12'h000; we = 0; rs1 = 0; imm = 0;
    pc = 0; trap = 0; mcause_in = 0; mret = 0; retired = 0; irq = 0;
  endtask

  task automatic csr_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] v);
    opcode = op; addr = a; we = 1;
    if (op[2]) imm = v; else rs1 = v;
  endtask

  logic [11:0] addr_pool [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // Reset values
    addr = 12'h305; #1;
    chk("mtvec_reset", rd, 32'h100);
    addr = 12'h300; #1;
    chk("mstatus_reset", rd, 32'h1800);
    chk("pending_reset", 32'(pend), 32'd0);
    chk("cause_reset", cause, 32'd0);
    chk("illegal_reset", 32'(illegal), 32'd0);
    run_cycle();

    // mie write masking
    csr_op(3'b010, 12'h304, 32'hFFFF_FFFF); run_cycle();
    chk("mie_rs_mask", mie_o, 32'h000F_0000);
    csr_op(3'b111, 12'h304, 32'h0); run_cycle();
    chk("mie_rci_zero", mie_o, 32'h000F_0000);

    // Interrupt pending, then trap capture
    idle(); csr_op(3'b110, 12'h300, 32'h8); run_cycle();
    csr_op(3'b001, 12'h304, 32'h0002_0000); run_cycle();
    idle(); irq = 4'b0010; run_cycle();
    chk("irq_pending", 32'(pend), 32'd1);
    chk("irq_cause_17", cause, 32'h8000_0011);
    trap = 1; pc = 32'h0000_0203; mcause_in = 32'h8000_0011; run_cycle();
    idle(); addr = 12'h300; #1;
    chk("trap_mepc", mepc_o, 32'h200);
    chk("trap_mstatus", rd, 32'h1880);
    run_cycle();

    // trap + mret + write in one cycle, then mret alone
    csr_op(3'b001, 12'h340, 32'h1234_5678); run_cycle();
    csr_op(3'b110, 12'h300, 32'h8); run_cycle();
    csr_op(3'b001, 12'h340, 32'hDEAD_BEEF); trap = 1; mret = 1; pc = 32'h400;
    mcause_in = 32'h2; run_cycle();
    idle(); addr = 12'h340; #1;
    chk("mscratch_kept", rd, 32'h1234_5678);
    chk("trap_wins_mepc", mepc_o, 32'h400);
    mret = 1; run_cycle();
    idle(); addr = 12'h300; #1;
    chk("mret_mstatus", rd, 32'h1888);
    run_cycle();

    // mcycle wrap
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF); run_cycle();
    csr_op(3'b001, 12'hB80, 32'hFFFF_FFFF); run_cycle();
    idle(); run_cycle();
    addr = 12'hB00; #1;
    chk("mcycle_wrap_lo", rd, 32'h0);
    addr = 12'hB80; #1;
    chk("mcycle_wrap_hi", rd, 32'h0);
    run_cycle();

    // Unmapped write, and counters absent when disabled
    csr_op(3'b001, 12'h7C0, 32'hCAFE_0001); #1;
    chk("illegal_7c0", 32'(illegal), 32'd1);
    run_cycle();
    idle(); addr = 12'hB00; #1;
    chk("nc_mcycle_read", rd_nc, 32'h0);
    run_cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rst       = ($urandom_range(0, 99) == 0);
      opcode    = 3'($urandom);
      addr      = addr_pool[$urandom_range(0, 11)];
      we        = $urandom_range(0, 1) == 1;
      rs1       = $urandom;
      imm       = 32'($urandom_range(0, 31));
      pc        = $urandom;
      mcause_in = $urandom;
      trap      = ($urandom_range(0, 15) == 0);
      mret      = ($urandom_range(0, 7) == 0);
      retired   = $urandom_range(0, 1) == 1;
      irq       = IRQ_NUM'($urandom);
      if (mret && addr == 12'h300) we = 0;
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_file_ext.md
CSR_FILE_EXT -- requirements
Module: csr_file_ext

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 16, number of local interrupt lines (legal 1..16).
REQ-002 SHALL have parameter COUNTERS_EN, default 1, which implements mcycle/minstret when 1.
REQ-003 SHALL have parameter RESET_MTVEC, default 32'h0, which is the mtvec reset value.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-005 SHALL have these ports:
- clk_i  in  1  clock.
- rst_i  in  1  sync active-high reset.
- opcode_i  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- addr_i  in  12  CSR address.
- write_enable_i  in  1  CSR write request.
- rs1_data_i  in  32  register operand.
- imm_data_i  in  32  zero-extended immediate operand.
- pc_i  in  32  PC of trapping instruction.
- trap_i  in  1  trap taken this cycle.
- mcause_i  in  32  trap cause.
- mret_i  in  1  mret executed this cycle.
- instr_retired_i  in  1  one instruction retired this cycle.
- irq_i  in  IRQ_NUM  level interrupt lines.
- read_data_o  out  32  CSR read data.
- mie_o, mepc_o, mtvec_o  out  32 each  register contents.
- irq_pending_o  out  1  enabled interrupt pending.
- irq_cause_o  out  32  cause for highest-priority pending interrupt.
- illegal_csr_o  out  1  write to an unmapped CSR.

Function
REQ-006 SHALL implement this map:
- mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344.
- If COUNTERS_EN=1: mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
REQ-007 SHALL drive read_data_o combinationally with the current (pre-update) register value; unmapped addresses read 0.
REQ-008 SHALL compute write data as follows:
- RW: operand. RS: old | operand. RC: old & ~operand.
- Operand is rs1_data_i for 00x/01x ops and imm_data_i for 1xx ops.
- Opcodes 000/100 perform no write.
REQ-009 SHALL perform a CSR write on the clock edge where write_enable_i=1, the address is mapped and writable, and trap_i=0.
REQ-010 SHALL assert illegal_csr_o combinationally when write_enable_i=1 and addr_i is unmapped; no state changes in that case.
REQ-011 SHALL implement mstatus with only bit3 (MIE) and bit7 (MPIE) writable, bits[12:11] (MPP) reading 2'b11, and all other bits reading 0.
REQ-012 SHALL make mie bits [16+IRQ_NUM-1:16] writable; all other mie bits read 0.
REQ-013 SHALL register irq_i into mip bits [16+IRQ_NUM-1:16] every cycle (1-cycle latency); mip is read-only, writes to it are ignored, and illegal_csr_o stays 0.
REQ-014 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write and trap capture.
REQ-015 SHALL, on trap_i=1:
- set mepc<=pc_i, mcause<=mcause_i, MPIE<=MIE, MIE<=0;
- suppress every CSR write in that cycle.
REQ-016 SHALL, on mret_i=1 with trap_i=0, set MIE<=MPIE and MPIE<=1.
REQ-017 SHALL give trap_i priority when trap_i and mret_i are asserted together; mret_i is ignored.
REQ-018 SHALL, when COUNTERS_EN=1, increment the 64-bit mcycle every cycle and the 64-bit minstret in cycles where instr_retired_i=1.
REQ-019 SHALL wrap both counters from 2^64-1 to 0.
REQ-020 SHALL, on a CSR write to any half of a counter, load that half with the written value, leave the other half unchanged, and suppress that counter's increment for that cycle.
REQ-021 SHALL, when COUNTERS_EN=0, treat the counter addresses as unmapped.
REQ-022 SHALL drive irq_pending_o = MIE & |(mip & mie) combinationally from the registered state.
REQ-023 SHALL drive irq_cause_o = {1'b1, 31'(16+i)}, where i is the lowest pending-and-enabled index; irq_cause_o = 0 when nothing is pending.
REQ-024 SHALL drive mie_o, mepc_o and mtvec_o directly from the registers.

Reset
REQ-025 SHALL, on rst_i=1 at a clock edge, clear every register to 0 (mtvec to RESET_MTVEC), including mip and both counters.
REQ-026 SHALL have rst_i override trap_i, mret_i and any write in the same cycle.
REQ-027 SHALL hold irq_pending_o=0, irq_cause_o=0 and illegal_csr_o=0 after reset until inputs change.

Verification
REQ-028 Reset then read 0x305 with RESET_MTVEC=32'h100 -> read_data_o=32'h100; read 0x300 -> 32'h1800.
REQ-029 RS 0x304 with rs1=32'hFFFF_FFFF and IRQ_NUM=4 -> mie_o=32'h000F_0000; then RCI imm=0 -> unchanged.
REQ-030 Set MIE=1 and mie bit17, raise irq_i[1] -> irq_pending_o=1 one cycle later and irq_cause_o=32'h8000_0011; assert trap_i with pc_i=32'h0000_0203 -> mepc_o=32'h200, MIE=0, MPIE=1.
REQ-031 trap_i and mret_i together with an RW write to 0x340 -> mscratch unchanged, trap update only; then mret_i alone -> MIE=1.
REQ-032 Write mcycle=32'hFFFF_FFFF and mcycleh=32'hFFFF_FFFF -> next cycle reads mcycle=0, mcycleh=0 (wrap).
REQ-033 Write to 0x7C0 with write_enable_i=1 -> illegal_csr_o=1 and no register changes; COUNTERS_EN=0 read of 0xB00 -> 0.
